reg_checkpoint_monitor: RTL and testbench

//  Synthesizable end-of-test checker for the MIPS pipeline; replaces hand-written cycle/$display checks.

---
 rtl/chk_pkg.sv | 6 +
 rtl/chk_expect_bank.sv | 29 ++
 rtl/reg_checkpoint_monitor.sv | 128 ++++++++++++
 tb/tb_reg_checkpoint_monitor.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/chk_pkg.sv
// chk_pkg: shared state encoding and trigger-mode constants for the checkpoint monitor
package chk_pkg;
   typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_e;
   localparam logic TRIG_CYCLE = 1'b0;
   localparam logic TRIG_PC    = 1'b1;
endpackage

// File: rtl/chk_expect_bank.sv
// chk_expect_bank: per-channel expected values, sync write, async indexed read, sync clear
module chk_expect_bank
   import chk_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int NUM_CH = 8,
   parameter int IDX_W  = 3
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              we,
   input  logic [IDX_W-1:0]  widx,
   input  logic [DATA_W-1:0] wdata,
   input  logic [IDX_W-1:0]  ridx,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] mem_q [NUM_CH];
   logic [DATA_W-1:0] mem_d [NUM_CH];
   // next bank contents: one entry replaced on a write
   always_comb begin
      mem_d = mem_q;
      if (we) mem_d[widx] = wdata;
   end
   // bank register with synchronous clear
   always_ff @(posedge Clk) begin
      for (int i = 0; i < NUM_CH; i++) mem_q[i] <= Rst ? '0 : mem_d[i];
   end
   assign rdata = mem_q[ridx];
endmodule

// File: rtl/reg_checkpoint_monitor.sv
// reg_checkpoint_monitor: snapshots register taps at a checkpoint and checks them against an expected bank
module reg_checkpoint_monitor
   import chk_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int NUM_CH = 8,
   parameter int CYC_W  = 16,
   localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                     Clk,
   input  logic                     Rst,
   input  logic                     start,
   input  logic                     trig_mode,
   input  logic [CYC_W-1:0]         trig_cycle,
   input  logic [DATA_W-1:0]        trig_pc,
   input  logic [CYC_W-1:0]         timeout_cyc,
   input  logic [DATA_W-1:0]        pc_in,
   input  logic [NUM_CH*DATA_W-1:0] reg_taps,
   input  logic                     exp_we,
   input  logic [IDX_W-1:0]         exp_idx,
   input  logic [DATA_W-1:0]        exp_data,
   output logic                     busy,
   output logic                     done,
   output logic                     pass,
   output logic                     timed_out,
   output logic [NUM_CH-1:0]        fail_mask,
   output logic [IDX_W-1:0]         first_fail,
   output logic [CYC_W-1:0]         cycle_count
);
   state_e                   state_q, state_d;
   logic [CYC_W-1:0]         cyc_q, cyc_d;
   logic [IDX_W-1:0]         idx_q, idx_d, first_fail_q, first_fail_d;
   logic [NUM_CH-1:0]        fail_mask_q, fail_mask_d;
   logic [NUM_CH*DATA_W-1:0] snap_q, snap_d;
   logic                     pass_q, pass_d, timed_out_q, timed_out_d;
   logic [DATA_W-1:0]        exp_rd, snap_rd;
   logic                     trig, tmo, mis;

   chk_expect_bank #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .IDX_W(IDX_W)) u_bank (
      .Clk   (Clk),
      .Rst   (Rst),
      .we    (exp_we && !busy),
      .widx  (exp_idx),
      .wdata (exp_data),
      .ridx  (idx_q),
      .rdata (exp_rd)
   );

   // next-state, counter, snapshot capture and serial compare
   always_comb begin
      state_d      = state_q;
      cyc_d        = cyc_q;
      idx_d        = idx_q;
      first_fail_d = first_fail_q;
      fail_mask_d  = fail_mask_q;
      snap_d       = snap_q;
      pass_d       = pass_q;
      timed_out_d  = timed_out_q;
      trig         = (trig_mode == TRIG_PC) ? (pc_in == trig_pc) : (cyc_q == trig_cycle);
      tmo          = (timeout_cyc != '0) && (cyc_q == timeout_cyc) && !trig;
      snap_rd      = snap_q[idx_q*DATA_W +: DATA_W];
      mis          = snap_rd != exp_rd;
      case (state_q)
         IDLE, DONE: if (start) begin
            state_d      = RUN;
            cyc_d        = CYC_W'(1);
            fail_mask_d  = '0;
            first_fail_d = '0;
            pass_d       = 1'b0;
            timed_out_d  = 1'b0;
         end
         RUN: if (trig) begin
            state_d = CHECK;
            snap_d  = reg_taps;
            idx_d   = '0;
         end else if (tmo) begin
            state_d     = DONE;
            timed_out_d = 1'b1;
         end else begin
            cyc_d = &cyc_q ? cyc_q : cyc_q + 1'b1;
         end
         CHECK: begin
            if (mis) begin
               fail_mask_d[idx_q] = 1'b1;
               if (fail_mask_q == '0) first_fail_d = idx_q;
            end
            if (idx_q == IDX_W'(NUM_CH-1)) begin
               state_d = DONE;
               pass_d  = fail_mask_d == '0;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // state and result registers with synchronous reset
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q      <= IDLE;
         cyc_q        <= '0;
         idx_q        <= '0;
         first_fail_q <= '0;
         fail_mask_q  <= '0;
         snap_q       <= '0;
         pass_q       <= 1'b0;
         timed_out_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         cyc_q        <= cyc_d;
         idx_q        <= idx_d;
         first_fail_q <= first_fail_d;
         fail_mask_q  <= fail_mask_d;
         snap_q       <= snap_d;
         pass_q       <= pass_d;
         timed_out_q  <= timed_out_d;
      end
   end

   assign busy        = (state_q == RUN) || (state_q == CHECK);
   assign done        = state_q == DONE;
   assign pass        = pass_q;
   assign timed_out   = timed_out_q;
   assign fail_mask   = fail_mask_q;
   assign first_fail  = first_fail_q;
   assign cycle_count = cyc_q;
endmodule

// File: tb/tb_reg_checkpoint_monitor.sv
// tb_reg_checkpoint_monitor: directed checks of trigger, compare, timeout and reset behaviour
module tb_reg_checkpoint_monitor;
   localparam int DATA_W = 32;
   localparam int NUM_CH = 8;
   localparam int CYC_W  = 16;

   logic                     Clk = 1'b0;
   logic                     Rst = 1'b1;
   logic                     start = 1'b0;
   logic                     trig_mode = 1'b0;
   logic [CYC_W-1:0]         trig_cycle = '0;
   logic [DATA_W-1:0]        trig_pc = '0;
   logic [CYC_W-1:0]         timeout_cyc = '0;
   logic [DATA_W-1:0]        pc_in = '0;
   logic [NUM_CH*DATA_W-1:0] reg_taps = '0;
   logic                     exp_we = 1'b0;
   logic [2:0]               exp_idx = '0;
   logic [DATA_W-1:0]        exp_data = '0;
   logic                     busy, done, pass, timed_out;
   logic [NUM_CH-1:0]        fail_mask;
   logic [2:0]               first_fail;
   logic [CYC_W-1:0]         cycle_count;

   int checks = 0;
   int failures = 0;

   reg_checkpoint_monitor #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .CYC_W(CYC_W)) dut (
      .Clk(Clk), .Rst(Rst), .start(start), .trig_mode(trig_mode), .trig_cycle(trig_cycle),
      .trig_pc(trig_pc), .timeout_cyc(timeout_cyc), .pc_in(pc_in), .reg_taps(reg_taps),
      .exp_we(exp_we), .exp_idx(exp_idx), .exp_data(exp_data), .busy(busy), .done(done),
      .pass(pass), .timed_out(timed_out), .fail_mask(fail_mask), .first_fail(first_fail),
      .cycle_count(cycle_count)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge Clk);
      #1;
   endtask

   task automatic load_exp();
      for (int i = 0; i < NUM_CH; i++) begin
         exp_we = 1'b1; exp_idx = 3'(i); exp_data = 32'(4*(i+1));
         tick(1);
      end
      exp_we = 1'b0;
   endtask

   task automatic taps_match();
      for (int i = 0; i < NUM_CH; i++) reg_taps[i*DATA_W +: DATA_W] = 32'(4*(i+1));
   endtask

   task automatic go();
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   task automatic check_idle_zero(input string tag);
      check({tag, "_busy"}, 64'(busy), 0);
      check({tag, "_done"}, 64'(done), 0);
      check({tag, "_pass"}, 64'(pass), 0);
      check({tag, "_to"}, 64'(timed_out), 0);
      check({tag, "_mask"}, 64'(fail_mask), 0);
      check({tag, "_ff"}, 64'(first_fail), 0);
      check({tag, "_cyc"}, 64'(cycle_count), 0);
   endtask

   initial begin
      tick(2);
      Rst = 1'b0;
      check_idle_zero("reset");

      // 1: matching taps, cycle trigger at 14, ignored start while busy
      load_exp();
      taps_match();
      trig_mode = 1'b0; trig_cycle = 16'd14; timeout_cyc = '0;
      go();
      check("s1_cyc1", 64'(cycle_count), 1);
      tick(4);
      start = 1'b1; tick(1); start = 1'b0;
      tick(8);
      check("s1_cyc14", 64'(cycle_count), 14);
      tick(8);
      check("s1_busy", 64'(busy), 1);
      check("s1_notdone", 64'(done), 0);
      tick(1);
      check("s1_done", 64'(done), 1);
      check("s1_pass", 64'(pass), 1);
      check("s1_mask", 64'(fail_mask), 0);
      check("s1_cyc", 64'(cycle_count), 14);
      check("s1_to", 64'(timed_out), 0);

      // 2: two mismatching channels
      reg_taps[2*DATA_W +: DATA_W] = 32'd13;
      reg_taps[5*DATA_W +: DATA_W] = 32'd0;
      go();
      tick(21);
      check("s2_notdone", 64'(done), 0);
      tick(1);
      check("s2_done", 64'(done), 1);
      check("s2_pass", 64'(pass), 0);
      check("s2_mask", 64'(fail_mask), 64'h24);
      check("s2_ff", 64'(first_fail), 2);

      // 3: PC trigger at 120, last channel mismatches
      taps_match();
      reg_taps[7*DATA_W +: DATA_W] = 32'd1;
      trig_mode = 1'b1; trig_pc = 32'd120;
      go();
      pc_in = 32'd100;
      for (int k = 1; k <= 14; k++) begin
         tick(1);
         pc_in = 32'(100 + 4*k);
         if (k == 13) check("s3_notdone", 64'(done), 0);
      end
      check("s3_done", 64'(done), 1);
      check("s3_cyc", 64'(cycle_count), 6);
      check("s3_pass", 64'(pass), 0);
      check("s3_mask", 64'(fail_mask), 64'h80);
      check("s3_ff", 64'(first_fail), 7);
      check("s3_cleared_to", 64'(timed_out), 0);

      // 4a: timeout before the checkpoint
      taps_match();
      trig_mode = 1'b0; trig_cycle = 16'd50; timeout_cyc = 16'd20;
      go();
      tick(19);
      check("s4a_cyc20", 64'(cycle_count), 20);
      check("s4a_notdone", 64'(done), 0);
      tick(1);
      check("s4a_done", 64'(done), 1);
      check("s4a_to", 64'(timed_out), 1);
      check("s4a_pass", 64'(pass), 0);
      check("s4a_mask", 64'(fail_mask), 0);
      check("s4a_cyc", 64'(cycle_count), 20);

      // 4b: trigger and timeout coincide, trigger wins
      trig_cycle = 16'd20;
      go();
      tick(20);
      check("s4b_busy", 64'(busy), 1);
      check("s4b_notdone", 64'(done), 0);
      tick(8);
      check("s4b_done", 64'(done), 1);
      check("s4b_to", 64'(timed_out), 0);
      check("s4b_pass", 64'(pass), 1);
      check("s4b_cyc", 64'(cycle_count), 20);

      // 5: taps change after trigger, bank write attempted during CHECK
      timeout_cyc = '0; trig_cycle = 16'd14;
      go();
      tick(14);
      reg_taps = '0;
      exp_we = 1'b1; exp_idx = 3'd3; exp_data = 32'd999;
      tick(3);
      exp_we = 1'b0;
      tick(5);
      check("s5_done", 64'(done), 1);
      check("s5_pass", 64'(pass), 1);
      check("s5_mask", 64'(fail_mask), 0);
      taps_match();
      go();
      tick(22);
      check("s5_bank_pass", 64'(pass), 1);

      // 6: reset mid-CHECK clears everything including the bank
      go();
      tick(16);
      check("s6_busy", 64'(busy), 1);
      Rst = 1'b1;
      tick(1);
      Rst = 1'b0;
      check_idle_zero("s6_rst");
      go();
      tick(22);
      check("s6_bank0_mask", 64'(fail_mask), 64'hFF);
      check("s6_bank0_ff", 64'(first_fail), 0);
      reg_taps = '0;
      go();
      tick(22);
      check("s6_zero_pass", 64'(pass), 1);
      load_exp();
      taps_match();
      go();
      tick(22);
      check("s6_reload_done", 64'(done), 1);
      check("s6_reload_pass", 64'(pass), 1);
      check("s6_reload_cyc", 64'(cycle_count), 14);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
